// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: ALU priority, FIFO-buffered long-latency path.
// Optional macro RF_WB_BYPASS_EN lets an idle-cycle long-latency write skip the FIFO.
module rf_wb_arbiter #(
    parameter int n          = 32,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alu_valid,
    input  logic [4:0]                    alu_rd,
    input  logic [n-1:0]                  alu_data,
    output logic                          alu_ready,
    input  logic                          lu_valid,
    input  logic [4:0]                    lu_rd,
    input  logic [n-1:0]                  lu_data,
    output logic                          lu_ready,
    output logic                          Wr_en,
    output logic [4:0]                    rd,
    output logic [n-1:0]                  Wr_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic {S_NORM, S_FORCE} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   starve_cnt_q, starve_cnt_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            wr_en_q, wr_en_d;
    logic [4:0]      rd_q, rd_d;
    logic [n-1:0]    wr_data_q, wr_data_d;

    logic [4:0]      rd_mem_q   [FIFO_DEPTH];
    logic [n-1:0]    data_mem_q [FIFO_DEPTH];

    logic            fifo_empty;
    logic            grant_alu, grant_fifo, grant_byp;
    logic            push, pop, any_grant;
    logic [4:0]      sel_rd;
    logic [n-1:0]    sel_data;

    always_comb begin
        fifo_empty = (count_q == '0);
        alu_ready  = (state_q == S_NORM);
        lu_ready   = (count_q < CW'(FIFO_DEPTH));

        grant_alu  = 1'b0;
        grant_fifo = 1'b0;
        grant_byp  = 1'b0;
        unique case (state_q)
            S_NORM: begin
                if (alu_valid) begin
                    grant_alu = 1'b1;
                end else if (!fifo_empty) begin
                    grant_fifo = 1'b1;
                end else begin
`ifdef RF_WB_BYPASS_EN
                    grant_byp = lu_valid;
`else
                    grant_byp = 1'b0;
`endif
                end
            end
            S_FORCE: grant_fifo = !fifo_empty;
            default: grant_fifo = 1'b0;
        endcase

        push      = lu_valid && lu_ready && !grant_byp;
        pop       = grant_fifo;
        any_grant = grant_alu || grant_fifo || grant_byp;

        sel_rd   = lu_rd;
        sel_data = lu_data;
        if (grant_alu) begin
            sel_rd   = alu_rd;
            sel_data = alu_data;
        end else if (grant_fifo) begin
            sel_rd   = rd_mem_q[rd_ptr_q];
            sel_data = data_mem_q[rd_ptr_q];
        end

        // x0 writes are consumed but never reach the register file
        wr_en_d   = any_grant && (sel_rd != 5'd0);
        rd_d      = wr_en_d ? sel_rd : rd_q;
        wr_data_d = wr_en_d ? sel_data : wr_data_q;

        starve_cnt_d = starve_cnt_q;
        if (fifo_empty || grant_fifo) begin
            starve_cnt_d = '0;
        end else if (grant_alu) begin
            starve_cnt_d = starve_cnt_q + SW'(1);
        end

        state_d = S_NORM;
        if (state_q == S_NORM && !fifo_empty &&
            starve_cnt_d == SW'(STARVE_MAX)) begin
            state_d = S_FORCE;
        end

        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_NORM;
            starve_cnt_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            wr_en_q      <= 1'b0;
            rd_q         <= '0;
            wr_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            wr_en_q      <= wr_en_d;
            rd_q         <= rd_d;
            wr_data_q    <= wr_data_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem_q[wr_ptr_q]   <= lu_rd;
            data_mem_q[wr_ptr_q] <= lu_data;
        end
    end

    assign Wr_en      = wr_en_q;
    assign rd         = rd_q;
    assign Wr_data    = wr_data_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter (default parameters).
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        Wr_en;
    logic [4:0]  rd;
    logic [31:0] Wr_data;
    logic [1:0]  fifo_count;

    int errors = 0;
    int checks = 0;

    rf_wb_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .alu_ready  (alu_ready),
        .lu_valid   (lu_valid),
        .lu_rd      (lu_rd),
        .lu_data    (lu_data),
        .lu_ready   (lu_ready),
        .Wr_en      (Wr_en),
        .rd         (rd),
        .Wr_data    (Wr_data),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0;
        alu_rd    = 5'd0;
        alu_data  = 32'd0;
        lu_valid  = 1'b0;
        lu_rd     = 5'd0;
        lu_data   = 32'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (Wr_en !== 1'b0 || rd !== 5'd0 || Wr_data !== 32'd0 ||
                alu_ready !== 1'b1 || lu_ready !== 1'b1 || fifo_count !== 2'd0) begin
                errors++;
                $display("FAIL reset_idle[%0d]: got en=%b rd=%0d data=%h ar=%b lr=%b cnt=%0d want 0 0 0 1 1 0",
                         i, Wr_en, rd, Wr_data, alu_ready, lu_ready, fifo_count);
            end
            tick();
        end
    endtask

    task automatic test_alu_write();
        do_reset();
        tick();
        tick();
        alu_valid = 1'b1;
        alu_rd    = 5'd5;
        alu_data  = 32'hDEADBEEF;
        checks++;
        if (alu_ready !== 1'b1) begin
            errors++;
            $display("FAIL alu_ready_pre: got %b want 1", alu_ready);
        end
        tick();
        alu_valid = 1'b0;
        checks++;
        if (Wr_en !== 1'b1 || rd !== 5'd5 || Wr_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL alu_write: got en=%b rd=%0d data=%h want 1 5 deadbeef", Wr_en, rd, Wr_data);
        end
        tick();
        checks++;
        if (Wr_en !== 1'b0 || rd !== 5'd5 || Wr_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL alu_after: got en=%b rd=%0d data=%h want 0 5 deadbeef", Wr_en, rd, Wr_data);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        alu_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            alu_rd   = 5'(i);
            alu_data = 32'h100 * i;
            tick();
            checks++;
            if (Wr_en !== 1'b1 || rd !== 5'(i) || Wr_data !== 32'h100 * i) begin
                errors++;
                $display("FAIL b2b[%0d]: got en=%b rd=%0d data=%h want 1 %0d %h",
                         i, Wr_en, rd, Wr_data, i, 32'h100 * i);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_fifo_fill();
        do_reset();
        alu_valid = 1'b1;
        alu_rd    = 5'd1;
        alu_data  = 32'h11;
        lu_valid  = 1'b1;
        lu_rd     = 5'd7;
        lu_data   = 32'h70;
        tick();
        checks++;
        if (fifo_count !== 2'd1 || lu_ready !== 1'b1 || Wr_en !== 1'b1 || rd !== 5'd1) begin
            errors++;
            $display("FAIL fill_1: got cnt=%0d lr=%b en=%b rd=%0d want 1 1 1 1", fifo_count, lu_ready, Wr_en, rd);
        end
        lu_rd   = 5'd9;
        lu_data = 32'h90;
        tick();
        checks++;
        if (fifo_count !== 2'd2 || lu_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_2: got cnt=%0d lr=%b want 2 0", fifo_count, lu_ready);
        end
        lu_rd   = 5'd11;
        lu_data = 32'hB0;
        tick();
        checks++;
        if (fifo_count !== 2'd2 || lu_ready !== 1'b0 || rd !== 5'd1) begin
            errors++;
            $display("FAIL fill_stall: got cnt=%0d lr=%b rd=%0d want 2 0 1", fifo_count, lu_ready, rd);
        end
        alu_valid = 1'b0;
        tick();
        checks++;
        if (Wr_en !== 1'b1 || rd !== 5'd7 || Wr_data !== 32'h70 ||
            fifo_count !== 2'd1 || lu_ready !== 1'b1) begin
            errors++;
            $display("FAIL drain_7: got en=%b rd=%0d data=%h cnt=%0d lr=%b want 1 7 70 1 1",
                     Wr_en, rd, Wr_data, fifo_count, lu_ready);
        end
        tick();
        checks++;
        if (Wr_en !== 1'b1 || rd !== 5'd9 || Wr_data !== 32'h90 || fifo_count !== 2'd1) begin
            errors++;
            $display("FAIL drain_9_enq: got en=%b rd=%0d data=%h cnt=%0d want 1 9 90 1",
                     Wr_en, rd, Wr_data, fifo_count);
        end
        lu_valid = 1'b0;
        tick();
        checks++;
        if (Wr_en !== 1'b1 || rd !== 5'd11 || Wr_data !== 32'hB0 || fifo_count !== 2'd0) begin
            errors++;
            $display("FAIL drain_11_wrap: got en=%b rd=%0d data=%h cnt=%0d want 1 11 b0 0",
                     Wr_en, rd, Wr_data, fifo_count);
        end
        tick();
        checks++;
        if (Wr_en !== 1'b0 || rd !== 5'd11) begin
            errors++;
            $display("FAIL drain_idle: got en=%b rd=%0d want 0 11", Wr_en, rd);
        end
    endtask

    task automatic test_starvation();
        do_reset();
        alu_valid = 1'b1;
        alu_rd    = 5'd3;
        alu_data  = 32'h33;
        lu_valid  = 1'b1;
        lu_rd     = 5'd7;
        lu_data   = 32'h77;
        tick();
        lu_valid = 1'b0;
        checks++;
        if (Wr_en !== 1'b1 || rd !== 5'd3 || fifo_count !== 2'd1) begin
            errors++;
            $display("FAIL starve_enq: got en=%b rd=%0d cnt=%0d want 1 3 1", Wr_en, rd, fifo_count);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (alu_ready !== 1'b1) begin
                errors++;
                $display("FAIL starve_ready[%0d]: got %b want 1", i, alu_ready);
            end
            tick();
            checks++;
            if (Wr_en !== 1'b1 || rd !== 5'd3 || fifo_count !== 2'd1) begin
                errors++;
                $display("FAIL starve_alu[%0d]: got en=%b rd=%0d cnt=%0d want 1 3 1",
                         i, Wr_en, rd, fifo_count);
            end
        end
        checks++;
        if (alu_ready !== 1'b0) begin
            errors++;
            $display("FAIL starve_force: alu_ready got %b want 0", alu_ready);
        end
        tick();
        checks++;
        if (Wr_en !== 1'b1 || rd !== 5'd7 || Wr_data !== 32'h77 ||
            fifo_count !== 2'd0 || alu_ready !== 1'b1) begin
            errors++;
            $display("FAIL starve_grant: got en=%b rd=%0d data=%h cnt=%0d ar=%b want 1 7 77 0 1",
                     Wr_en, rd, Wr_data, fifo_count, alu_ready);
        end
        tick();
        checks++;
        if (Wr_en !== 1'b1 || rd !== 5'd3) begin
            errors++;
            $display("FAIL starve_resume: got en=%b rd=%0d want 1 3", Wr_en, rd);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_x0();
        do_reset();
        alu_valid = 1'b1;
        alu_rd    = 5'd0;
        alu_data  = 32'hAA;
        lu_valid  = 1'b1;
        lu_rd     = 5'd0;
        lu_data   = 32'h55;
        checks++;
        if (alu_ready !== 1'b1) begin
            errors++;
            $display("FAIL x0_ack: alu_ready got %b want 1", alu_ready);
        end
        tick();
        idle_inputs();
        checks++;
        if (Wr_en !== 1'b0 || fifo_count !== 2'd1) begin
            errors++;
            $display("FAIL x0_alu: got en=%b cnt=%0d want 0 1", Wr_en, fifo_count);
        end
        tick();
        checks++;
        if (Wr_en !== 1'b0 || fifo_count !== 2'd0 || rd !== 5'd0 || Wr_data !== 32'd0) begin
            errors++;
            $display("FAIL x0_fifo: got en=%b cnt=%0d rd=%0d data=%h want 0 0 0 0",
                     Wr_en, fifo_count, rd, Wr_data);
        end
    endtask

    task automatic test_reset_midop();
        do_reset();
        alu_valid = 1'b1;
        alu_rd    = 5'd2;
        alu_data  = 32'h22;
        lu_valid  = 1'b1;
        lu_rd     = 5'd7;
        lu_data   = 32'h70;
        tick();
        lu_rd   = 5'd9;
        lu_data = 32'h90;
        tick();
        checks++;
        if (Wr_en !== 1'b1 || fifo_count !== 2'd2) begin
            errors++;
            $display("FAIL midrst_pre: got en=%b cnt=%0d want 1 2", Wr_en, fifo_count);
        end
        idle_inputs();
        rst = 1'b1;
        tick();
        checks++;
        if (Wr_en !== 1'b0 || fifo_count !== 2'd0 || rd !== 5'd0) begin
            errors++;
            $display("FAIL midrst_clear: got en=%b cnt=%0d rd=%0d want 0 0 0", Wr_en, fifo_count, rd);
        end
        rst = 1'b0;
        checks++;
        if (alu_ready !== 1'b1 || lu_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_ready: got ar=%b lr=%b want 1 1", alu_ready, lu_ready);
        end
        lu_valid = 1'b1;
        lu_rd    = 5'd12;
        lu_data  = 32'hC0;
        tick();
        lu_valid = 1'b0;
`ifdef RF_WB_BYPASS_EN
        checks++;
        if (Wr_en !== 1'b1 || rd !== 5'd12 || Wr_data !== 32'hC0 || fifo_count !== 2'd0) begin
            errors++;
            $display("FAIL bypass: got en=%b rd=%0d data=%h cnt=%0d want 1 12 c0 0",
                     Wr_en, rd, Wr_data, fifo_count);
        end
`else
        checks++;
        if (Wr_en !== 1'b0 || fifo_count !== 2'd1) begin
            errors++;
            $display("FAIL lu_lat_1: got en=%b cnt=%0d want 0 1", Wr_en, fifo_count);
        end
        tick();
        checks++;
        if (Wr_en !== 1'b1 || rd !== 5'd12 || Wr_data !== 32'hC0 || fifo_count !== 2'd0) begin
            errors++;
            $display("FAIL lu_lat_2: got en=%b rd=%0d data=%h cnt=%0d want 1 12 c0 0",
                     Wr_en, rd, Wr_data, fifo_count);
        end
`endif
        tick();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_alu_write();
        test_back_to_back();
        test_fifo_fill();
        test_starvation();
        test_x0();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
